// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the pipeline stages.
// Load/store funct3 encodings and the memory-stage FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the memory stage.
// Store mask/replication and load extract with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  opsel,
  input  logic [1:0]  off,
  input  logic        wen,
  input  logic [31:0] wd,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    mask  = 4'hF;
    wdata = wd;
    unique case (1'b1)
      opsel[1:0] == 2'b00: begin
        mask  = 4'b0001 << off;
        wdata = {4{wd[7:0]}};
      end
      opsel[1:0] == 2'b01: begin
        mask  = 4'b0011 << {off[1], 1'b0};
        wdata = {2{wd[15:0]}};
      end
      default: begin
        mask  = 4'hF;
        wdata = wd;
      end
    endcase
    if (!wen)
      mask = 4'h0;
  end

  assign lb = rdata[{off, 3'b000} +: 8];
  assign lh = rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata;
    unique case (1'b1)
      opsel == F3_B:  load_data = {{24{lb[7]}}, lb};
      opsel == F3_H:  load_data = {{16{lh[15]}}, lh};
      opsel == F3_BU: load_data = {24'h0, lb};
      opsel == F3_HU: load_data = {16'h0, lh};
      default:        load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: data-memory request/ready handshake, wait timeout,
// and the MEM/WB pipeline register.
module mem_stage
  import riscv_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1,
  parameter int WAIT_MAX    = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [31:0] i_res,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_reg,
  input  logic [2:0]  i_opsel,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_ready,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_vld,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic [31:0] o_wb_data,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  localparam logic [3:0] LAST = 4'(WAIT_MAX - 1);

  state_t      state, state_n;
  logic [3:0]  cnt;
  logic        ldst, mis_raw, mis, acc;
  logic        timeout, abort;
  logic [31:0] load_data;

  assign ldst = i_vld & (i_mem_read | i_mem_write);

  always_comb begin
    mis_raw = 1'b0;
    if (ALIGN_CHECK) begin
      unique case (1'b1)
        i_opsel == F3_H,
        i_opsel == F3_HU: mis_raw = i_dmem_addr[0];
        i_opsel == F3_W:  mis_raw = |i_dmem_addr[1:0];
        default:          mis_raw = 1'b0;
      endcase
    end
  end

  assign mis     = ldst & mis_raw;
  assign acc     = ldst & ~mis_raw;
  assign timeout = (state == ST_WAIT) && (cnt == LAST);
  // Ready in the timeout cycle still completes the access normally.
  assign abort   = acc & ~i_dmem_ready & timeout;
  assign o_stall = acc & ~i_dmem_ready & ~timeout;

  assign o_dmem_addr = {i_dmem_addr[31:2], 2'b00};
  assign o_dmem_ren  = acc & i_mem_read;
  assign o_dmem_wen  = acc & i_mem_write;

  lsu_align u_align (
    .opsel     (i_opsel),
    .off       (i_dmem_addr[1:0]),
    .wen       (o_dmem_wen),
    .wd        (i_dmem_wdata),
    .rdata     (i_dmem_rdata),
    .mask      (o_dmem_mask),
    .wdata     (o_dmem_wdata),
    .load_data (load_data)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (o_stall)  state_n = ST_WAIT;
      ST_WAIT: if (!o_stall) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= (state == ST_WAIT) ? cnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vld        <= 1'b0;
      o_rd_wen     <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else if (o_stall) begin
      o_vld        <= 1'b0;
      o_rd_wen     <= 1'b0;
      o_misaligned <= 1'b0;
      o_bus_err    <= 1'b0;
    end else begin
      o_vld        <= i_vld;
      o_rd_wen     <= i_vld & i_rd_wen & ~mis & ~abort;
      o_misaligned <= mis;
      o_bus_err    <= abort;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!o_stall) begin
      o_rd_waddr <= i_rd_waddr;
      o_wb_data  <= i_mem_reg ? load_data : i_res;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard on the MEM/WB port.
// Request-side outputs are checked inline; writebacks by the monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_vld;
  logic [31:0] i_res;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic        i_mem_read;
  logic        i_mem_write;
  logic        i_mem_reg;
  logic [2:0]  i_opsel;
  logic [4:0]  i_rd_waddr;
  logic        i_rd_wen;
  logic [31:0] o_dmem_addr;
  logic        o_dmem_ren;
  logic        o_dmem_wen;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_mask;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;
  logic        o_stall;
  logic        o_vld;
  logic [4:0]  o_rd_waddr;
  logic        o_rd_wen;
  logic [31:0] o_wb_data;
  logic        o_misaligned;
  logic        o_bus_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  waddr;
    logic        wen;
    logic [31:0] data;
    logic        cd;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage #(.ALIGN_CHECK(1'b1), .WAIT_MAX(15)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_vld        (i_vld),
    .i_res        (i_res),
    .i_dmem_addr  (i_dmem_addr),
    .i_dmem_wdata (i_dmem_wdata),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_mem_reg    (i_mem_reg),
    .i_opsel      (i_opsel),
    .i_rd_waddr   (i_rd_waddr),
    .i_rd_wen     (i_rd_wen),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_ren   (o_dmem_ren),
    .o_dmem_wen   (o_dmem_wen),
    .o_dmem_wdata (o_dmem_wdata),
    .o_dmem_mask  (o_dmem_mask),
    .i_dmem_ready (i_dmem_ready),
    .i_dmem_rdata (i_dmem_rdata),
    .o_stall      (o_stall),
    .o_vld        (o_vld),
    .o_rd_waddr   (o_rd_waddr),
    .o_rd_wen     (o_rd_wen),
    .o_wb_data    (o_wb_data),
    .o_misaligned (o_misaligned),
    .o_bus_err    (o_bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_vld        = 1'b0;
    i_mem_read   = 1'b0;
    i_mem_write  = 1'b0;
    i_mem_reg    = 1'b0;
    i_dmem_ready = 1'b0;
    i_rd_wen     = 1'b0;
  endtask

  task automatic req(input logic rd, input logic wr, input logic mreg,
                     input logic [2:0] op, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] res,
                     input logic [4:0] wa, input logic rwen);
    i_vld        = 1'b1;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_mem_reg    = mreg;
    i_opsel      = op;
    i_dmem_addr  = addr;
    i_dmem_wdata = wd;
    i_res        = res;
    i_rd_waddr   = wa;
    i_rd_wen     = rwen;
  endtask

  task automatic push(input logic [4:0] wa, input logic wen,
                      input logic [31:0] d, input logic cd,
                      input logic mis, input logic berr);
    exp_t e;
    e.waddr = wa;
    e.wen   = wen;
    e.data  = d;
    e.cd    = cd;
    e.mis   = mis;
    e.berr  = berr;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!i_rst && o_vld) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wb actual=vld required=none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_waddr", 32'(o_rd_waddr), 32'(e.waddr));
        chk("wb_rd_wen", 32'(o_rd_wen), 32'(e.wen));
        chk("wb_misaligned", 32'(o_misaligned), 32'(e.mis));
        chk("wb_bus_err", 32'(o_bus_err), 32'(e.berr));
        if (e.cd)
          chk("wb_data", o_wb_data, e.data);
      end
    end
  end

  initial begin
    int n;
    idle_in();
    i_res        = '0;
    i_dmem_addr  = '0;
    i_dmem_wdata = '0;
    i_opsel      = '0;
    i_rd_waddr   = '0;
    i_dmem_rdata = '0;
    i_rst        = 1'b1;
    cyc();
    cyc();
    i_rst = 1'b0;
    #1;
    chk("rst_vld", 32'(o_vld), 0);
    chk("rst_rd_wen", 32'(o_rd_wen), 0);
    chk("rst_mis", 32'(o_misaligned), 0);
    chk("rst_berr", 32'(o_bus_err), 0);
    chk("rst_stall", 32'(o_stall), 0);
    chk("rst_ren", 32'(o_dmem_ren), 0);
    chk("rst_wen", 32'(o_dmem_wen), 0);
    cyc();

    // LB 0x103 with immediate ready
    req(1, 0, 1, 3'b000, 32'h103, 0, 0, 5, 1);
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'h80FF_1234;
    push(5, 1, 32'hFFFF_FF80, 1, 0, 0);
    #1;
    chk("lb_stall", 32'(o_stall), 0);
    chk("lb_ren", 32'(o_dmem_ren), 1);
    chk("lb_wen", 32'(o_dmem_wen), 0);
    chk("lb_mask", 32'(o_dmem_mask), 0);
    chk("lb_addr", o_dmem_addr, 32'h100);
    cyc();

    // SH 0x202
    req(0, 1, 0, 3'b001, 32'h202, 32'h0000_ABCD, 32'h1234, 2, 0);
    i_dmem_ready = 1'b1;
    push(2, 0, 32'h1234, 1, 0, 0);
    #1;
    chk("sh_mask", 32'(o_dmem_mask), 32'hC);
    chk("sh_wdata", o_dmem_wdata, 32'hABCD_ABCD);
    chk("sh_addr", o_dmem_addr, 32'h200);
    chk("sh_wen", 32'(o_dmem_wen), 1);
    chk("sh_stall", 32'(o_stall), 0);
    cyc();

    // SB 0x101 and SW 0x700
    req(0, 1, 0, 3'b000, 32'h101, 32'h1122_3344, 32'h55, 4, 0);
    push(4, 0, 32'h55, 1, 0, 0);
    #1;
    chk("sb_mask", 32'(o_dmem_mask), 32'h2);
    chk("sb_wdata", o_dmem_wdata, 32'h4444_4444);
    cyc();
    req(0, 1, 0, 3'b010, 32'h700, 32'h1122_3344, 32'h66, 4, 0);
    push(4, 0, 32'h66, 1, 0, 0);
    #1;
    chk("sw_mask", 32'(o_dmem_mask), 32'hF);
    chk("sw_wdata", o_dmem_wdata, 32'h1122_3344);
    cyc();

    // Load extract variants on 0x8001_7FFF
    i_dmem_rdata = 32'h8001_7FFF;
    req(1, 0, 1, 3'b101, 32'h102, 0, 0, 6, 1);
    push(6, 1, 32'h0000_8001, 1, 0, 0);
    cyc();
    req(1, 0, 1, 3'b001, 32'h102, 0, 0, 7, 1);
    push(7, 1, 32'hFFFF_8001, 1, 0, 0);
    cyc();
    req(1, 0, 1, 3'b100, 32'h101, 0, 0, 8, 1);
    push(8, 1, 32'h0000_007F, 1, 0, 0);
    cyc();

    // Non-access pass-through to x0
    req(0, 0, 0, 3'b010, 32'h3, 0, 32'hCAFE_F00D, 0, 1);
    push(0, 1, 32'hCAFE_F00D, 1, 0, 0);
    #1;
    chk("alu_stall", 32'(o_stall), 0);
    cyc();

    // LW with ready delayed 3 cycles
    req(1, 0, 1, 3'b010, 32'h300, 0, 0, 7, 1);
    i_dmem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lw_wait_stall", 32'(o_stall), 1);
      chk("lw_wait_ren", 32'(o_dmem_ren), 1);
      cyc();
    end
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'hDEAD_BEEF;
    push(7, 1, 32'hDEAD_BEEF, 1, 0, 0);
    #1;
    chk("lw_done_stall", 32'(o_stall), 0);
    cyc();

    // Misaligned LH
    idle_in();
    req(1, 0, 1, 3'b001, 32'h101, 0, 0, 3, 1);
    push(3, 0, 0, 0, 1, 0);
    #1;
    chk("mis_ren", 32'(o_dmem_ren), 0);
    chk("mis_stall", 32'(o_stall), 0);
    cyc();

    // SW timeout
    idle_in();
    req(0, 1, 0, 3'b010, 32'h400, 32'h1, 0, 9, 1);
    push(9, 0, 0, 0, 0, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (o_stall)
        n++;
      else
        break;
      cyc();
    end
    chk("to_stall_cycles", 32'(n), 15);
    cyc();
    idle_in();
    req(1, 0, 1, 3'b010, 32'h404, 0, 0, 10, 1);
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'h0BAD_F00D;
    push(10, 1, 32'h0BAD_F00D, 1, 0, 0);
    #1;
    chk("post_to_stall", 32'(o_stall), 0);
    cyc();

    // Ready on the timeout cycle wins
    idle_in();
    req(1, 0, 1, 3'b010, 32'h600, 0, 0, 11, 1);
    for (int k = 0; k < 15; k++)
      cyc();
    i_dmem_ready = 1'b1;
    i_dmem_rdata = 32'h1234_5678;
    push(11, 1, 32'h1234_5678, 1, 0, 0);
    #1;
    chk("rdy_win_stall", 32'(o_stall), 0);
    cyc();

    // Reset during WAIT
    idle_in();
    req(1, 0, 1, 3'b010, 32'h500, 0, 0, 12, 1);
    #1;
    chk("rstw_stall0", 32'(o_stall), 1);
    cyc();
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    idle_in();
    #1;
    chk("rstw_stall", 32'(o_stall), 0);
    chk("rstw_vld", 32'(o_vld), 0);
    chk("rstw_ren", 32'(o_dmem_ren), 0);
    chk("rstw_wen", 32'(o_dmem_wen), 0);

    for (int k = 0; k < 4; k++)
      cyc();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
